// File: rtl/acc_pkg.sv
// Shared encodings for the accumulator execution stage.
package acc_pkg;

  localparam int DEF_WIDTH = 16;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_MUL  = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/acc_exec_unit_if.sv
// Request/status bundle between the control sequencer and the accumulator stage.
interface acc_exec_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc;
  logic             busy;
  logic             done;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, op, operand,
    input  acc, busy, done, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  start, op, operand,
    output acc, busy, done, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/acc_alu_comb.sv
// Single-cycle ALU: result plus carry/borrow and signed overflow.
module acc_alu_comb
  import acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] res,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Extended add/sub so the top bit carries out carry resp. borrow.
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res  = a;
    c    = 1'b0;
    v    = 1'b0;
    unique case (op)
      OP_LOAD: res = b;
      OP_ADD: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = diff[WIDTH-1:0];
        c   = diff[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_MUL:  res = a;            // handled by the iterative path
      OP_CLR:  res = '0;
    endcase
  end

endmodule

// File: rtl/acc_exec_unit.sv
// Accumulator execution stage: single-cycle ALU ops plus iterative shift-add MUL.
module acc_exec_unit
  import acc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MUL_ITERS = WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  acc_exec_unit_if.slave bus
);

  localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITERS - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  flags_t             flags_q, flags_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [2*WIDTH-1:0] prod_sum;
  op_e                op_in;

  assign op_in = op_e'(bus.op);

  acc_alu_comb #(.WIDTH(WIDTH)) u_alu (
    .a   (acc_q),
    .b   (bus.operand),
    .op  (op_in),
    .res (alu_res),
    .c   (alu_c),
    .v   (alu_v)
  );

  // Partial product for this iteration, including the current add.
  always_comb begin
    prod_sum = prod_q;
    if (mplier_q[0])
      prod_sum = prod_q + ({{WIDTH{1'b0}}, mcand_q} << cnt_q);
  end

  // Next-state: accept in IDLE, iterate in MUL, write acc + flags on completion.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    flags_d  = flags_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (op_in == OP_MUL) begin
            // Multiplicand is the current acc; operand only sampled here.
            mcand_d  = acc_q;
            mplier_d = bus.operand;
            prod_d   = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = ST_MUL;
          end else begin
            acc_d   = alu_res;
            flags_d = '{z: (alu_res == '0), n: alu_res[WIDTH-1], c: alu_c, v: alu_v};
            done_d  = 1'b1;
          end
        end
      end
      ST_MUL: begin
        prod_d   = prod_sum;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          acc_d   = prod_sum[WIDTH-1:0];
          flags_d = '{z: (prod_sum[WIDTH-1:0] == '0), n: prod_sum[WIDTH-1],
                      c: (prod_sum[2*WIDTH-1:WIDTH] != '0), v: 1'b0};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; async reset abandons any MUL in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      flags_q  <= flags_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.acc    = acc_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.flag_z = flags_q.z;
  assign bus.flag_n = flags_q.n;
  assign bus.flag_c = flags_q.c;
  assign bus.flag_v = flags_q.v;

endmodule

// File: tb/tb_acc_exec_unit.sv
// Bench for acc_exec_unit: directed cases plus random traffic against a behavioural model.
module tb_acc_exec_unit;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  acc_exec_unit_if #(.WIDTH(W)) bus();

  acc_exec_unit #(.WIDTH(W), .MUL_ITERS(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  logic [15:0] m_acc  = '0;
  logic        m_z    = 1'b0;
  logic        m_n    = 1'b0;
  logic        m_c    = 1'b0;
  logic        m_v    = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [31:0] m_prod = '0;

  function automatic logic [31:0] pack(logic [15:0] a, logic b, logic d,
                                       logic z, logic n, logic c, logic v);
    return {10'b0, a, b, d, z, n, c, v};
  endfunction

  function automatic logic [31:0] dut_vec();
    return pack(bus.acc, bus.busy, bus.done, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v);
  endfunction

  function automatic logic [31:0] model_vec();
    return pack(m_acc, (m_left != 0), m_done, m_z, m_n, m_c, m_v);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got acc/busy/done/zncv=%h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge of the architectural behaviour.
  task automatic model_step();
    logic        wr;
    logic [15:0] r;
    logic        c, v;
    int          s, sa, sb;
    wr = 1'b0; r = m_acc; c = 1'b0; v = 1'b0;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        r  = m_prod[15:0];
        c  = (m_prod[31:16] != 0);
        wr = 1'b1;
      end
    end else if (bus.start) begin
      wr = 1'b1;
      sa = int'($signed(m_acc));
      sb = int'($signed(bus.operand));
      case (bus.op)
        3'd0: r = bus.operand;
        3'd1: begin
          s = int'(m_acc) + int'(bus.operand);
          r = 16'(s);
          c = (s > 65535);
          v = (sa + sb > 32767) || (sa + sb < -32768);
        end
        3'd2: begin
          r = m_acc - bus.operand;
          c = (m_acc < bus.operand);
          v = (sa - sb > 32767) || (sa - sb < -32768);
        end
        3'd3: r = m_acc & bus.operand;
        3'd4: r = m_acc | bus.operand;
        3'd5: r = m_acc ^ bus.operand;
        3'd6: begin
          m_prod = 32'(m_acc) * 32'(bus.operand);
          m_left = W;
          wr     = 1'b0;
        end
        default: r = 16'h0000;
      endcase
    end
    if (wr) begin
      m_acc = r;
      m_z   = (r == 16'h0000);
      m_n   = r[15];
      m_c   = c;
      m_v   = v;
    end
    m_done = wr;
  endtask

  // Model follows clock edges and the asynchronous reset.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_acc = '0; m_z = 0; m_n = 0; m_c = 0; m_v = 0; m_done = 0; m_left = 0;
    end else begin
      model_step();
    end
  end

  // Every cycle: DUT outputs must match the model.
  initial forever begin
    @(negedge clk);
    chk("cycle", dut_vec(), model_vec());
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(logic [2:0] op, logic [15:0] opd);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.operand = opd;
    tick();
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.operand = 16'h0000;
    #3;
    chk("reset_state", dut_vec(), 32'h0);
    #9 rst_n = 1'b1;

    // Asynchronous reset mid-cycle
    tick();
    go(3'd0, 16'h5A5A);
    bus.start = 1'b0;
    chk("load_5a5a", dut_vec(), pack(16'h5A5A, 0, 1, 0, 0, 0, 0));
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("async_reset", dut_vec(), 32'h0);
    tick(); rst_n = 1'b1;

    // LOAD 7FFF then ADD 1: signed overflow, back-to-back done
    go(3'd0, 16'h7FFF);
    chk("load_7fff", dut_vec(), pack(16'h7FFF, 0, 1, 0, 0, 0, 0));
    go(3'd1, 16'h0001);
    bus.start = 1'b0;
    chk("add_ovf", dut_vec(), pack(16'h8000, 0, 1, 0, 1, 0, 1));
    tick();
    chk("done_drop", dut_vec(), pack(16'h8000, 0, 0, 0, 1, 0, 1));

    // LOAD 3, SUB 5 (borrow), XOR to zero
    go(3'd0, 16'h0003);
    go(3'd2, 16'h0005);
    chk("sub_borrow", dut_vec(), pack(16'hFFFE, 0, 1, 0, 1, 1, 0));
    go(3'd5, 16'hFFFE);
    bus.start = 1'b0;
    chk("xor_zero", dut_vec(), pack(16'h0000, 0, 1, 1, 0, 0, 0));

    // LOAD 0123, MUL 0010 with an ignored CLR and a wandering operand
    go(3'd0, 16'h0123);
    go(3'd6, 16'h0010);
    bus.start = 1'b0;
    chk("mul_busy_0", dut_vec(), pack(16'h0123, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 15; k++) begin
      bus.start   = (k == 4);
      bus.op      = (k == 4) ? 3'd7 : 3'd6;
      bus.operand = 16'($urandom);
      tick();
      chk("mul_busy", dut_vec(), pack(16'h0123, 1, 0, 0, 0, 0, 0));
    end
    bus.start = 1'b0;
    tick();
    chk("mul_result", dut_vec(), pack(16'h1230, 0, 1, 0, 0, 0, 0));
    tick();
    chk("mul_done_drop", dut_vec(), pack(16'h1230, 0, 0, 0, 0, 0, 0));

    // LOAD 1000, MUL 0100: product spills entirely into the high half
    go(3'd0, 16'h1000);
    go(3'd6, 16'h0100);
    bus.start = 1'b0;
    repeat (16) tick();
    chk("mul_carry", dut_vec(), pack(16'h0000, 0, 1, 1, 0, 1, 0));

    // Reset during MUL iteration 8, then a normal LOAD
    go(3'd0, 16'h0F0F);
    go(3'd6, 16'h0003);
    bus.start = 1'b0;
    repeat (7) tick();
    #2 rst_n = 1'b0;
    #1 chk("mul_reset", dut_vec(), 32'h0);
    tick(); rst_n = 1'b1;
    tick();
    chk("no_done_after_reset", dut_vec(), 32'h0);
    go(3'd0, 16'h00AA);
    bus.start = 1'b0;
    chk("load_after_reset", dut_vec(), pack(16'h00AA, 0, 1, 0, 0, 0, 0));

    // Random traffic, biased toward boundary operands
    repeat (600) begin
      bus.start = 1'($urandom_range(0, 1));
      bus.op    = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 7))
        0: bus.operand = 16'h0000;
        1: bus.operand = 16'hFFFF;
        2: bus.operand = 16'h8000;
        3: bus.operand = 16'h7FFF;
        default: bus.operand = 16'($urandom);
      endcase
      tick();
    end
    bus.start = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
